// File: rtl/led_matrix_pkg.sv
// Shared definitions for the LED matrix scan controller.
// Optional feature macro: SCAN_BLANK_EN (inserts a blanking gap after every column).
package led_matrix_pkg;

    localparam int unsigned NUM_COLS_DEF = 5;
    localparam int unsigned NUM_ROWS_DEF = 7;

    // Column drive is active-low, so "all off" is all ones.
    localparam logic [NUM_COLS_DEF-1:0] COLS_ALL_OFF = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRIVE = 2'd2
`ifdef SCAN_BLANK_EN
        ,
        ST_BLANK = 2'd3
`endif
    } scan_state_e;

    // Counter width: clog2 of the larger interval, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/scan_dwell_timer.sv
// Loadable down-counter; tc_c flags that the current interval ends this cycle.
// Holds at zero instead of wrapping.
module scan_dwell_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reload on request, otherwise count down and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_c = (cnt_q == '0);

endmodule

// File: rtl/led_matrix_scan_controller.sv
// Time-multiplexed column scanner for the 5x7 irrigation status matrix.
// Latches the decoder row images once per frame and drives one column at a
// time for DWELL_CYCLES clocks. Define SCAN_BLANK_EN to add BLANK_CYCLES of
// all-off blanking after every column.
module led_matrix_scan_controller
    import led_matrix_pkg::*;
#(
    parameter int unsigned NUM_COLS     = NUM_COLS_DEF,
    parameter int unsigned NUM_ROWS     = NUM_ROWS_DEF,
    parameter int unsigned DWELL_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [NUM_COLS*NUM_ROWS-1:0] frame_rows,
    output logic [NUM_COLS-1:0]          columns,
    output logic [NUM_ROWS-1:0]          rows,
    output logic                         frame_done
);

    localparam int unsigned IMG_W = NUM_COLS * NUM_ROWS;
    localparam int unsigned IDX_W = (NUM_COLS < 2) ? 1 : $clog2(NUM_COLS);
    localparam int unsigned CNT_W = cnt_width(DWELL_CYCLES, BLANK_CYCLES);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_COLS - 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
`ifdef SCAN_BLANK_EN
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
`endif

    scan_state_e         state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IMG_W-1:0]    shadow_q, shadow_d;
    logic [NUM_COLS-1:0] columns_q, columns_d;
    logic [NUM_ROWS-1:0] rows_q, rows_d;
    logic                frame_done_q, frame_done_d;

    logic                col_done_c;
    logic                tmr_load;
    logic [CNT_W-1:0]    tmr_val;
    logic                tmr_tc_c;

    // Single timer shared by dwell and blank intervals.
    scan_dwell_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc_c     (tmr_tc_c)
    );

    // Next-state, column advance and frame-end logic.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        frame_done_d = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = DWELL_LOAD;
        col_done_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shadow_d = frame_rows;
                idx_d    = '0;
                tmr_load = 1'b1;
                tmr_val  = DWELL_LOAD;
                state_d  = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (tmr_tc_c) begin
`ifdef SCAN_BLANK_EN
                    tmr_load = 1'b1;
                    tmr_val  = BLANK_LOAD;
                    state_d  = ST_BLANK;
`else
                    col_done_c = 1'b1;
`endif
                end
            end
`ifdef SCAN_BLANK_EN
            ST_BLANK: begin
                if (tmr_tc_c) begin
                    col_done_c = 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // enable is only looked at here and in IDLE, i.e. at frame boundaries.
        if (col_done_c) begin
            if (idx_q != LAST_IDX) begin
                idx_d    = idx_q + IDX_W'(1);
                tmr_load = 1'b1;
                tmr_val  = DWELL_LOAD;
                state_d  = ST_DRIVE;
            end else begin
                frame_done_d = 1'b1;
                state_d      = enable ? ST_LOAD : ST_IDLE;
            end
        end
    end

    // Output image for the state being entered, so outputs change on that edge.
    always_comb begin
        columns_d = '1;
        rows_d    = '0;
        if (state_d == ST_DRIVE) begin
            for (int unsigned c = 0; c < NUM_COLS; c++) begin
                if (idx_d == IDX_W'(c)) begin
                    columns_d[c] = 1'b0;
                    rows_d       = shadow_d[c*NUM_ROWS +: NUM_ROWS];
                end
            end
        end
    end

    // State, shadow image and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            shadow_q     <= '0;
            columns_q    <= '1;
            rows_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            columns_q    <= columns_d;
            rows_q       <= rows_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign columns    = columns_q;
    assign rows       = rows_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_matrix_scan_controller.sv
// Self-checking bench for led_matrix_scan_controller (DWELL=4, BLANK=1).
// Works with or without SCAN_BLANK_EN defined.
module tb_led_matrix_scan_controller;

    localparam int unsigned NC = 5;
    localparam int unsigned NR = 7;
    localparam int unsigned DW = 4;
    localparam int unsigned BW = 1;
`ifdef SCAN_BLANK_EN
    localparam int unsigned SLOT       = DW + BW;
    localparam int          EXP_PERIOD = 26;
`else
    localparam int unsigned SLOT       = DW;
    localparam int          EXP_PERIOD = 21;
`endif
    localparam int FRAME_LEN = 1 + NC * SLOT;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic [NC*NR-1:0]     frame_rows;
    logic [NC-1:0]        columns;
    logic [NR-1:0]        rows;
    logic                 frame_done;

    always #5 clk = ~clk;

    led_matrix_scan_controller #(
        .NUM_COLS     (NC),
        .NUM_ROWS     (NR),
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BW)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .frame_rows (frame_rows),
        .columns    (columns),
        .rows       (rows),
        .frame_done (frame_done)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: position within the frame, counted from the LOAD cycle.
    bit               m_busy = 1'b0;
    int               m_k    = 0;
    logic [NC*NR-1:0] m_img  = '0;
    bit               m_done = 1'b0;
    logic [NC-1:0]    e_cols;
    logic [NR-1:0]    e_rows;
    logic             e_done;

    // One clock: update the model with the inputs seen at the edge, then
    // derive the expected outputs at the following falling edge.
    task automatic cycle();
        int j;
        int col;
        @(posedge clk);
        if (reset) begin
            m_busy = 1'b0;
            m_k    = 0;
            m_done = 1'b0;
            m_img  = '0;
        end else if (!m_busy) begin
            m_done = 1'b0;
            if (enable) begin
                m_busy = 1'b1;
                m_k    = 0;
            end
        end else begin
            m_k = m_k + 1;
            if (m_k == 1) m_img = frame_rows;
            if (m_k == FRAME_LEN) begin
                m_done = 1'b1;
                m_k    = 0;
                m_busy = enable;
            end else begin
                m_done = 1'b0;
            end
        end
        @(negedge clk);
        e_cols = '1;
        e_rows = '0;
        e_done = m_done;
        if (m_busy && m_k >= 1) begin
            j   = m_k - 1;
            col = j / SLOT;
            if ((j % SLOT) < DW) begin
                e_cols[col] = 1'b0;
                e_rows      = m_img[col*NR +: NR];
            end
        end
    endtask

    // Run until the model sits at frame offset target (always at least one clock).
    task automatic advance_to(input int target, input string name);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(m_busy && m_k == target) && n < 3 * FRAME_LEN);
        if (!(m_busy && m_k == target)) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s: frame offset %0d not reached within %0d cycles", name, target, n);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        enable     = 1'b1;
        frame_rows = '1;
        repeat (3) begin
            cycle();
            tests_run++;
            if ({columns, rows, frame_done} !== {5'b11111, 7'h00, 1'b0}) begin
                tests_failed++;
                $display("FAIL reset_hold: got cols=%b rows=%h done=%b, want cols=11111 rows=00 done=0",
                         columns, rows, frame_done);
            end
        end
        reset = 1'b0;
        cycle();
        tests_run++;
        if ({columns, rows, frame_done} !== {5'b11111, 7'h00, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_load: got cols=%b rows=%h done=%b, want cols=11111 rows=00 done=0",
                     columns, rows, frame_done);
        end
        cycle();
        tests_run++;
        if ({columns, rows, frame_done} !== {5'b11110, 7'h7F, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_first_col: got cols=%b rows=%h done=%b, want cols=11110 rows=7f done=0",
                     columns, rows, frame_done);
        end
    endtask

    task automatic test_scan_all_on();
        int cyc;
        int last_done;
        int n_done;
        cyc       = 0;
        last_done = -1;
        n_done    = 0;
        enable     = 1'b1;
        frame_rows = '1;
        repeat (2 * FRAME_LEN + 3) begin
            cycle();
            cyc++;
            tests_run++;
            if ({columns, rows, frame_done} !== {e_cols, e_rows, e_done}) begin
                tests_failed++;
                $display("FAIL scan_all_on cyc %0d: got cols=%b rows=%h done=%b, want cols=%b rows=%h done=%b",
                         cyc, columns, rows, frame_done, e_cols, e_rows, e_done);
            end
            if (frame_done === 1'b1) begin
                n_done++;
                if (last_done >= 0) begin
                    tests_run++;
                    if (cyc - last_done != EXP_PERIOD) begin
                        tests_failed++;
                        $display("FAIL frame_period: got %0d cycles, want %0d", cyc - last_done, EXP_PERIOD);
                    end
                end
                last_done = cyc;
            end
        end
        tests_run++;
        if (n_done < 2) begin
            tests_failed++;
            $display("FAIL frame_done_count: got %0d pulses, want at least 2", n_done);
        end
    endtask

    task automatic test_no_tearing();
        enable = 1'b1;
        for (int c = 0; c < NC; c++) frame_rows[c*NR +: NR] = 7'($urandom);
        frame_rows[2*NR +: NR] = 7'h01;
        advance_to(0, "tear_load");
        advance_to(1 + SLOT, "tear_col1");
        frame_rows[2*NR +: NR] = 7'h7E;
        advance_to(1 + 2 * SLOT, "tear_col2");
        tests_run++;
        if ({columns, rows} !== {5'b11011, 7'h01}) begin
            tests_failed++;
            $display("FAIL no_tearing_this_frame: got cols=%b rows=%h, want cols=11011 rows=01", columns, rows);
        end
        advance_to(1 + 2 * SLOT, "tear_next_col2");
        tests_run++;
        if ({columns, rows} !== {5'b11011, 7'h7E}) begin
            tests_failed++;
            $display("FAIL no_tearing_next_frame: got cols=%b rows=%h, want cols=11011 rows=7e", columns, rows);
        end
    endtask

    task automatic test_enable_drop();
        int n_done;
        int n;
        n_done = 0;
        n      = 0;
        enable = 1'b1;
        advance_to(1 + SLOT, "drop_col1");
        enable = 1'b0;
        while (m_busy && n < FRAME_LEN + 2) begin
            cycle();
            n++;
            tests_run++;
            if ({columns, rows, frame_done} !== {e_cols, e_rows, e_done}) begin
                tests_failed++;
                $display("FAIL enable_drop cyc %0d: got cols=%b rows=%h done=%b, want cols=%b rows=%h done=%b",
                         n, columns, rows, frame_done, e_cols, e_rows, e_done);
            end
            if (frame_done === 1'b1) n_done++;
        end
        tests_run++;
        if (n_done != 1 || m_busy) begin
            tests_failed++;
            $display("FAIL enable_drop_done: got %0d pulses, want 1", n_done);
        end
        repeat (4) begin
            cycle();
            tests_run++;
            if ({columns, rows, frame_done} !== {5'b11111, 7'h00, 1'b0}) begin
                tests_failed++;
                $display("FAIL enable_drop_idle: got cols=%b rows=%h done=%b, want cols=11111 rows=00 done=0",
                         columns, rows, frame_done);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        enable     = 1'b1;
        frame_rows = '1;
        advance_to(1 + 3 * SLOT, "rst_col3");
        cycle();
        reset = 1'b1;
        cycle();
        tests_run++;
        if ({columns, rows, frame_done} !== {5'b11111, 7'h00, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_mid_frame: got cols=%b rows=%h done=%b, want cols=11111 rows=00 done=0",
                     columns, rows, frame_done);
        end
        reset  = 1'b0;
        enable = 1'b0;
        repeat (3) begin
            cycle();
            tests_run++;
            if ({columns, rows, frame_done} !== {5'b11111, 7'h00, 1'b0}) begin
                tests_failed++;
                $display("FAIL reset_mid_idle: got cols=%b rows=%h done=%b, want cols=11111 rows=00 done=0",
                         columns, rows, frame_done);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            enable     = ($urandom_range(0, 9) != 0);
            frame_rows = 35'({$urandom(), $urandom()});
            cycle();
            tests_run++;
            if ({columns, rows, frame_done} !== {e_cols, e_rows, e_done}) begin
                tests_failed++;
                $display("FAIL random cyc %0d: got cols=%b rows=%h done=%b, want cols=%b rows=%h done=%b",
                         i, columns, rows, frame_done, e_cols, e_rows, e_done);
            end
            tests_run++;
            if ($countones(~columns) > 1 || (&columns && rows != '0)) begin
                tests_failed++;
                $display("FAIL invariant cyc %0d: got cols=%b rows=%h, want at most one low column and rows=0 when none",
                         i, columns, rows);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        frame_rows = '0;
        test_reset();
        test_scan_all_on();
        test_no_tearing();
        test_enable_drop();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want bench to finish");
        $fatal(1, "watchdog");
    end

endmodule
